// File: rtl/bus_cycle_ctrl_if.sv
// Request/response and 8085 bus signals of bus_cycle_ctrl.
// slave = the controller; master = the microcode sequencer / bus environment.
interface bus_cycle_ctrl_if;
    logic        cyc_start;
    logic [2:0]  cyc_type;
    logic [15:0] cyc_addr;
    logic [7:0]  cyc_wdata;
    logic        ready;
    logic [7:0]  ad_in;
    logic        cyc_rdy;
    logic        cyc_done;
    logic [7:0]  cyc_rdata;
    logic        opcode_strobe;
    logic        cyc_timeout;
    logic [7:0]  haddress;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic        ALE;
    logic        RDn;
    logic        WRn;
    logic        IOMn;
    logic        S0;
    logic        S1;

    modport slave (
        input  cyc_start, cyc_type, cyc_addr, cyc_wdata, ready, ad_in,
        output cyc_rdy, cyc_done, cyc_rdata, opcode_strobe, cyc_timeout,
        output haddress, ad_out, ad_oe, ALE, RDn, WRn, IOMn, S0, S1
    );

    modport master (
        output cyc_start, cyc_type, cyc_addr, cyc_wdata, ready, ad_in,
        input  cyc_rdy, cyc_done, cyc_rdata, opcode_strobe, cyc_timeout,
        input  haddress, ad_out, ad_oe, ALE, RDn, WRn, IOMn, S0, S1
    );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// 8085 machine-cycle sequencer: T1/T2/TW/T3/T4 timing for OF, MR, MW, IOR, IOW.
// Optional READY timeout in TW is enabled by defining BUS_WAIT_TIMEOUT_EN.
module bus_cycle_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    bus_cycle_ctrl_if.slave   bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T1   = 3'd1;
    localparam logic [2:0] S_T2   = 3'd2;
    localparam logic [2:0] S_TW   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;

    localparam logic [2:0] TYP_OF  = 3'd0;
    localparam logic [2:0] TYP_MR  = 3'd1;
    localparam logic [2:0] TYP_MW  = 3'd2;
    localparam logic [2:0] TYP_IOR = 3'd3;
    localparam logic [2:0] TYP_IOW = 3'd4;

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("bus_cycle_ctrl: MAX_WAIT out of range 1..255");
    end

    logic [2:0]  state_q, state_d;
    logic [2:0]  type_q, type_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        ostb_q, ostb_d;

    logic is_read, is_write, final_st, accept, strobe_ph, active;

    assign is_read   = (type_q == TYP_OF) || (type_q == TYP_MR) || (type_q == TYP_IOR);
    assign is_write  = (type_q == TYP_MW) || (type_q == TYP_IOW);
    assign final_st  = (state_q == S_T4) || ((state_q == S_T3) && (type_q != TYP_OF));
    assign strobe_ph = (state_q == S_T2) || (state_q == S_TW) || (state_q == S_T3);
    assign active    = (state_q != S_IDLE);

    assign bus.cyc_rdy = (state_q == S_IDLE) || final_st;
    assign accept      = bus.cyc_start && bus.cyc_rdy && (bus.cyc_type <= TYP_IOW);

`ifdef BUS_WAIT_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
    logic [7:0] wcnt_q, wcnt_d;
    logic       tmo_q, tmo_d;
    logic       timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        ostb_d  = 1'b0;
`ifdef BUS_WAIT_TIMEOUT_EN
        wcnt_d    = wcnt_q;
        tmo_d     = tmo_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_T1:   state_d = S_T2;
            S_T2: begin
                state_d = bus.ready ? S_T3 : S_TW;
`ifdef BUS_WAIT_TIMEOUT_EN
                wcnt_d = '0;
`endif
            end
            S_TW: begin
                if (bus.ready) begin
                    state_d = S_T3;
                end
`ifdef BUS_WAIT_TIMEOUT_EN
                // wcnt_q counts completed TW clocks, so the last allowed one sees MAX_WAIT-1
                else if (wcnt_q == WAIT_LAST) begin
                    state_d = S_T3;
                    tmo_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
`endif
            end
            S_T3:   state_d = (type_q == TYP_OF) ? S_T4 : S_IDLE;
            S_T4:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_T3) && is_read) begin
            rdata_d = bus.ad_in;
        end

        if (final_st) begin
            done_d = 1'b1;
            ostb_d = (type_q == TYP_OF);
`ifdef BUS_WAIT_TIMEOUT_EN
            timeout_d = tmo_q;
`endif
        end

        // Acceptance in the final state overrides the return to IDLE (back-to-back)
        if (accept) begin
            state_d = S_T1;
            type_d  = bus.cyc_type;
            addr_d  = bus.cyc_addr;
            wdata_d = bus.cyc_wdata;
`ifdef BUS_WAIT_TIMEOUT_EN
            tmo_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            type_q  <= TYP_OF;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            ostb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            ostb_q  <= ostb_d;
        end
    end

`ifdef BUS_WAIT_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q    <= '0;
            tmo_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.cyc_timeout = timeout_q;
`else
    assign bus.cyc_timeout = 1'b0;
`endif

    assign bus.cyc_done      = done_q;
    assign bus.opcode_strobe = ostb_q;
    assign bus.cyc_rdata     = rdata_q;
    assign bus.haddress      = addr_q[15:8];

    assign bus.ALE  = (state_q == S_T1);
    assign bus.RDn  = !(strobe_ph && is_read);
    assign bus.WRn  = !(strobe_ph && is_write);
    assign bus.IOMn = active && ((type_q == TYP_IOR) || (type_q == TYP_IOW));
    assign bus.S1   = active && is_read;
    assign bus.S0   = active && ((type_q == TYP_OF) || is_write);

    always_comb begin
        bus.ad_oe  = 1'b0;
        bus.ad_out = '0;
        if (state_q == S_T1) begin
            bus.ad_oe  = 1'b1;
            bus.ad_out = addr_q[7:0];
        end else if (strobe_ph && is_write) begin
            bus.ad_oe  = 1'b1;
            bus.ad_out = wdata_q;
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed-vector bench for bus_cycle_ctrl; outputs sampled 1 ns after each rising edge.
module tb_bus_cycle_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bus_cycle_ctrl_if bus ();

    bus_cycle_ctrl #(.MAX_WAIT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] s10();
        return {bus.S1, bus.S0};
    endfunction

    initial begin
        bus.cyc_start = 1'b0;
        bus.cyc_type  = 3'd0;
        bus.cyc_addr  = 16'h0000;
        bus.cyc_wdata = 8'h00;
        bus.ready     = 1'b1;
        bus.ad_in     = 8'h00;

        // Reset and idle
        step(); step();
        rst = 1'b0;
        check("rst_rdn", bus.RDn, 1);
        check("rst_wrn", bus.WRn, 1);
        check("rst_ale", bus.ALE, 0);
        check("rst_oe", bus.ad_oe, 0);
        check("rst_adout", bus.ad_out, 8'h00);
        check("rst_s10", s10(), 2'b00);
        check("rst_iomn", bus.IOMn, 0);
        check("rst_haddr", bus.haddress, 8'h00);
        check("rst_rdata", bus.cyc_rdata, 8'h00);
        check("rst_rdy", bus.cyc_rdy, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_done", bus.cyc_done, 0);
            check("idle_rdn", bus.RDn, 1);
        end

        // Illegal type is ignored
        bus.cyc_start = 1'b1; bus.cyc_type = 3'd5; bus.cyc_addr = 16'hFFFF;
        step();
        bus.cyc_start = 1'b0;
        check("ill_ale", bus.ALE, 0);
        check("ill_haddr", bus.haddress, 8'h00);
        step();
        check("ill_done", bus.cyc_done, 0);

        // Opcode fetch at 0x1234
        bus.cyc_start = 1'b1; bus.cyc_type = 3'd0; bus.cyc_addr = 16'h1234;
        bus.ready = 1'b1; bus.ad_in = 8'h43;
        step();                                   // T1
        bus.cyc_start = 1'b0;
        check("of_t1_ale", bus.ALE, 1);
        check("of_t1_ad", bus.ad_out, 8'h34);
        check("of_t1_oe", bus.ad_oe, 1);
        check("of_t1_ha", bus.haddress, 8'h12);
        check("of_t1_s10", s10(), 2'b11);
        check("of_t1_iomn", bus.IOMn, 0);
        check("of_t1_rdn", bus.RDn, 1);
        check("of_t1_rdy", bus.cyc_rdy, 0);
        step();                                   // T2
        check("of_t2_ale", bus.ALE, 0);
        check("of_t2_rdn", bus.RDn, 0);
        check("of_t2_oe", bus.ad_oe, 0);
        step();                                   // T3
        check("of_t3_rdn", bus.RDn, 0);
        check("of_t3_rdy", bus.cyc_rdy, 0);
        step();                                   // T4
        check("of_t4_rdn", bus.RDn, 1);
        check("of_t4_s10", s10(), 2'b11);
        check("of_t4_rdy", bus.cyc_rdy, 1);
        check("of_t4_done", bus.cyc_done, 0);
        check("of_t4_rdata", bus.cyc_rdata, 8'h43);
        step();                                   // IDLE, done pulse
        check("of_done", bus.cyc_done, 1);
        check("of_ostb", bus.opcode_strobe, 1);
        check("of_tmo", bus.cyc_timeout, 0);
        check("of_idle_s10", s10(), 2'b00);
        check("of_idle_ha", bus.haddress, 8'h12);
        step();
        check("of_done_end", bus.cyc_done, 0);
        check("of_ostb_end", bus.opcode_strobe, 0);

        // Memory write at 0x80F0 with two wait states
        bus.cyc_start = 1'b1; bus.cyc_type = 3'd2; bus.cyc_addr = 16'h80F0;
        bus.cyc_wdata = 8'hA5; bus.ready = 1'b0;
        step();                                   // T1; a start here is not accepted
        bus.cyc_type = 3'd1; bus.cyc_addr = 16'h5555;
        check("mw_t1_ad", bus.ad_out, 8'hF0);
        check("mw_t1_ha", bus.haddress, 8'h80);
        check("mw_t1_s10", s10(), 2'b01);
        check("mw_t1_wrn", bus.WRn, 1);
        step();                                   // T2
        bus.cyc_start = 1'b0;
        check("mw_t2_wrn", bus.WRn, 0);
        check("mw_t2_rdn", bus.RDn, 1);
        check("mw_t2_ad", bus.ad_out, 8'hA5);
        check("mw_t2_oe", bus.ad_oe, 1);
        step();                                   // TW1
        check("mw_tw1_wrn", bus.WRn, 0);
        check("mw_tw1_oe", bus.ad_oe, 1);
        check("mw_tw1_ha", bus.haddress, 8'h80);
        step();                                   // TW2
        bus.ready = 1'b1;
        check("mw_tw2_wrn", bus.WRn, 0);
        check("mw_tw2_ad", bus.ad_out, 8'hA5);
        check("mw_tw2_rdy", bus.cyc_rdy, 0);
        step();                                   // T3
        check("mw_t3_wrn", bus.WRn, 0);
        check("mw_t3_rdy", bus.cyc_rdy, 1);
        check("mw_t3_iomn", bus.IOMn, 0);
        step();                                   // IDLE, done
        check("mw_done", bus.cyc_done, 1);
        check("mw_ostb", bus.opcode_strobe, 0);
        check("mw_idle_wrn", bus.WRn, 1);
        check("mw_idle_oe", bus.ad_oe, 0);
        check("mw_rdata_hold", bus.cyc_rdata, 8'h43);
        step();
        check("mw_no_extra", bus.ALE, 0);

        // IOR then IOW back-to-back
        bus.cyc_start = 1'b1; bus.cyc_type = 3'd3; bus.cyc_addr = 16'h4455;
        bus.ad_in = 8'h5A; bus.ready = 1'b1;
        step();                                   // IOR T1
        bus.cyc_start = 1'b0;
        check("ior_t1_iomn", bus.IOMn, 1);
        check("ior_t1_s10", s10(), 2'b10);
        check("ior_t1_ad", bus.ad_out, 8'h55);
        step();                                   // IOR T2
        check("ior_t2_rdn", bus.RDn, 0);
        check("ior_t2_wrn", bus.WRn, 1);
        step();                                   // IOR T3
        check("ior_t3_rdn", bus.RDn, 0);
        check("ior_t3_rdy", bus.cyc_rdy, 1);
        bus.cyc_start = 1'b1; bus.cyc_type = 3'd4; bus.cyc_addr = 16'h6677; bus.cyc_wdata = 8'h3C;
        step();                                   // IOW T1
        bus.cyc_start = 1'b0;
        check("b2b_ale", bus.ALE, 1);
        check("b2b_done", bus.cyc_done, 1);
        check("b2b_rdata", bus.cyc_rdata, 8'h5A);
        check("iow_t1_iomn", bus.IOMn, 1);
        check("iow_t1_s10", s10(), 2'b01);
        check("iow_t1_ad", bus.ad_out, 8'h77);
        check("iow_t1_ha", bus.haddress, 8'h66);
        check("iow_t1_strb", {bus.RDn, bus.WRn}, 2'b11);
        step();                                   // IOW T2
        check("iow_t2_strb", {bus.RDn, bus.WRn}, 2'b10);
        check("iow_t2_ad", bus.ad_out, 8'h3C);
        check("iow_t2_done", bus.cyc_done, 0);
        step();                                   // IOW T3
        check("iow_t3_strb", {bus.RDn, bus.WRn}, 2'b10);
        step();                                   // IDLE
        check("iow_done", bus.cyc_done, 1);
        check("iow_idle_iomn", bus.IOMn, 0);
        check("iow_idle_s10", s10(), 2'b00);

        // Reset during TW of an MR
        bus.cyc_start = 1'b1; bus.cyc_type = 3'd1; bus.cyc_addr = 16'h2000;
        bus.ready = 1'b0; bus.ad_in = 8'h99;
        step();                                   // T1
        bus.cyc_start = 1'b0;
        step();                                   // T2
        step();                                   // TW
        check("mr_tw_rdn", bus.RDn, 0);
        rst = 1'b1;
        step();
        rst = 1'b0; bus.ready = 1'b1;
        check("mrr_ale", bus.ALE, 0);
        check("mrr_rdn", bus.RDn, 1);
        check("mrr_oe", bus.ad_oe, 0);
        check("mrr_ha", bus.haddress, 8'h00);
        check("mrr_rdata", bus.cyc_rdata, 8'h00);
        check("mrr_done", bus.cyc_done, 0);
        check("mrr_s10", s10(), 2'b00);
        step();
        check("mrr_done2", bus.cyc_done, 0);
        bus.cyc_start = 1'b1; bus.cyc_type = 3'd1; bus.cyc_addr = 16'h2111; bus.ad_in = 8'h77;
        step();                                   // T1
        bus.cyc_start = 1'b0;
        check("mr2_t1_ha", bus.haddress, 8'h21);
        check("mr2_t1_s10", s10(), 2'b10);
        step(); step();                           // T2, T3
        check("mr2_t3_rdn", bus.RDn, 0);
        step();                                   // IDLE
        check("mr2_done", bus.cyc_done, 1);
        check("mr2_rdata", bus.cyc_rdata, 8'h77);
        check("mr2_ostb", bus.opcode_strobe, 0);

`ifdef BUS_WAIT_TIMEOUT_EN
        // READY stuck low: three TW clocks then a forced T3
        bus.cyc_start = 1'b1; bus.cyc_type = 3'd1; bus.cyc_addr = 16'h3003;
        bus.ready = 1'b0; bus.ad_in = 8'hC3;
        step();                                   // T1
        bus.cyc_start = 1'b0;
        step();                                   // T2
        for (int i = 0; i < 3; i++) begin
            step();                               // TW
            check("to_tw_rdn", bus.RDn, 0);
            check("to_tw_rdy", bus.cyc_rdy, 0);
        end
        step();                                   // T3
        check("to_t3_rdy", bus.cyc_rdy, 1);
        check("to_t3_tmo", bus.cyc_timeout, 0);
        step();
        check("to_done", bus.cyc_done, 1);
        check("to_tmo", bus.cyc_timeout, 1);
        check("to_rdata", bus.cyc_rdata, 8'hC3);
        step();
        check("to_tmo_end", bus.cyc_timeout, 0);
        bus.ready = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
